// File: rtl/fios_mm_sched.sv
// FIOS Montgomery multiplier control sequencer: start/done handshake, per-PE
// control decode, B/P fetch strobes, FOLD feedback select and result-valid strobe.

module fios_mm_pe_ctl #(
  parameter int KW    = 5,
  parameter int M_LAT = 3
) (
  input  logic          act,
  input  logic [KW-1:0] k,
  output logic          a_reg_en,
  output logic          m_reg_en,
  output logic          creg_en,
  output logic          res_dly_en,
  output logic          c_dly_en,
  output logic [1:0]    mux_a,
  output logic [1:0]    mux_b,
  output logic [1:0]    mux_c,
  output logic [8:0]    opmode
);
  always_comb begin
    a_reg_en   = 1'b0;
    m_reg_en   = 1'b0;
    creg_en    = 1'b0;
    res_dly_en = 1'b0;
    c_dly_en   = 1'b0;
    mux_a      = 2'd0;
    mux_b      = 2'd0;
    mux_c      = 2'd0;
    opmode     = 9'h000;
    if (act) begin
      creg_en  = 1'b1;
      m_reg_en = (k == KW'(1 + M_LAT));
      if (k == '0) begin
        a_reg_en = 1'b1;
        opmode   = 9'h035;
      end else if (k == KW'(1)) begin
        mux_a  = 2'd1;
        mux_b  = 2'd2;
        opmode = 9'h005;
      end else if (!k[0]) begin
        mux_c  = 2'd1;
        opmode = 9'h035;
      end else begin
        mux_a      = 2'd2;
        mux_b      = 2'd1;
        mux_c      = 2'd1;
        opmode     = 9'h0B5;
        c_dly_en   = 1'b1;
        res_dly_en = 1'b1;
      end
    end
  end
endmodule

module fios_mm_sched #(
  parameter int S        = 8,
  parameter int FOLD     = 0,
  parameter int PE_NB    = 8,
  parameter int PE_DELAY = 7,
  parameter int M_LAT    = 3,
  parameter int RES_LAT  = 4
) (
  input  logic                         clock_i,
  input  logic                         reset_n_i,
  input  logic                         start_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         bp_rd_en_o,
  output logic [$clog2(S)-1:0]         bp_addr_o,
  output logic [$clog2(S/PE_NB+1)-1:0] a_pass_o,
  output logic                         FIOS_input_sel_o,
  output logic                         res_valid_o,
  output logic [0:PE_NB-1]             a_reg_en_o,
  output logic [0:PE_NB-1]             m_reg_en_o,
  output logic [0:PE_NB-1]             CREG_en_o,
  output logic [0:PE_NB-1]             RES_delay_en_o,
  output logic [0:PE_NB-1]             C_input_delay_en_o,
  output logic [0:PE_NB-1][1:0]        mux_A_sel_o,
  output logic [0:PE_NB-1][1:0]        mux_B_sel_o,
  output logic [0:PE_NB-1][1:0]        mux_C_sel_o,
  output logic [0:PE_NB-1][8:0]        OPMODE_o
);
  localparam int   KW     = $clog2(2*S + 2);
  localparam int   AW     = $clog2(S);
  localparam int   PW     = $clog2(S/PE_NB + 1);
  localparam int   NPASS  = (S + PE_NB - 1) / PE_NB;
  localparam int   T0L    = 1 + (S-1)*PE_DELAY;     // start of the last iteration
  localparam int   T_LAST = T0L + 2*S + 1;          // last step of the last iteration
  localparam int   T_DONE = T_LAST + RES_LAT;
  localparam int   TW     = $clog2(T_DONE + 1);
  localparam logic T0P    = 1'(T0L % 2);

  if (FOLD != 0 && PE_NB*PE_DELAY < 2*S + 2) begin : g_err_fold
    $error("fios_mm_sched: PE_NB*PE_DELAY must be >= 2*S+2 in FOLD mode");
  end
  if (FOLD == 0 && PE_NB != S) begin : g_err_expand
    $error("fios_mm_sched: PE_NB must equal S in EXPAND mode");
  end

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
  state_e          state;
  logic [TW-1:0]   t;
  logic            run;
  logic            res_issue;
  logic [RES_LAT:1] vld_pipe;

  assign run = (state == RUN);

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state  <= IDLE;
      t      <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start_i) begin
          state  <= RUN;
          t      <= TW'(1);
          busy_o <= 1'b1;
        end
        RUN: begin
          t <= t + 1'b1;
          if (t == TW'(T_LAST)) state <= DRAIN;
        end
        DRAIN: begin
          if (t == TW'(T_DONE)) begin
            state  <= DONE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
          end else begin
            t <= t + 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          t      <= '0;
          done_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Iteration 0 fetches B/P one cycle ahead of each even step; the first fetch
  // coincides with start acceptance.
  always_comb begin
    bp_rd_en_o = ((state == IDLE) && start_i && reset_n_i) ||
                 (run && !t[0] && t >= TW'(2) && t <= TW'(2*S - 2));
    bp_addr_o  = bp_rd_en_o ? AW'(t >> 1) : '0;
  end

  always_comb begin
    FIOS_input_sel_o = 1'b0;
    a_pass_o         = '0;
    if (FOLD != 0 && run) begin
      if (PE_NB < S) FIOS_input_sel_o = (t >= TW'(1 + PE_NB*PE_DELAY));
      for (int q = 1; q < NPASS; q++)
        if (t >= TW'(1 + q*PE_NB*PE_DELAY)) a_pass_o = PW'(q);
    end
  end

  assign res_issue = run && t >= TW'(T0L + 3) && t <= TW'(T_LAST) && (t[0] != T0P);

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) vld_pipe <= '0;
    else begin
      vld_pipe[1] <= res_issue;
      for (int i = 2; i <= RES_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end
  assign res_valid_o = vld_pipe[RES_LAT];

  for (genvar p = 0; p < PE_NB; p++) begin : g_pe
    logic          act;
    logic [KW-1:0] k;
    // At most one iteration is live on a PE; k is its offset from that start.
    always_comb begin
      int st;
      act = 1'b0;
      k   = '0;
      st  = 0;
      for (int q = 0; q < NPASS; q++) begin
        st = 1 + (p + q*PE_NB)*PE_DELAY;
        if ((p + q*PE_NB) < S && run && t >= TW'(st) && t <= TW'(st + 2*S + 1)) begin
          act = 1'b1;
          k   = KW'(t - TW'(st));
        end
      end
    end

    fios_mm_pe_ctl #(.KW(KW), .M_LAT(M_LAT)) u_ctl (
      .act        (act),
      .k          (k),
      .a_reg_en   (a_reg_en_o[p]),
      .m_reg_en   (m_reg_en_o[p]),
      .creg_en    (CREG_en_o[p]),
      .res_dly_en (RES_delay_en_o[p]),
      .c_dly_en   (C_input_delay_en_o[p]),
      .mux_a      (mux_A_sel_o[p]),
      .mux_b      (mux_B_sel_o[p]),
      .mux_c      (mux_C_sel_o[p]),
      .opmode     (OPMODE_o[p])
    );
  end
endmodule

// File: tb/tb_fios_mm_sched.sv
// Scoreboard bench: two sequencers (EXPAND default, FOLD PE_NB=3) share stimulus;
// each accepted start pushes a full expected frame timeline built from the step rules.
module tb_fios_mm_sched;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        busy, done, rd, fsel, resv;
    logic [7:0]  addr, apass;
    logic [7:0]  aen, men, cen, ren, den;
    logic [15:0] ma, mb, mc;
    logic [71:0] op;
  } frame_t;

  // EXPAND instance
  logic busy0, done0, rd0, fsel0, resv0;
  logic [2:0] addr0; logic [0:0] apass0;
  logic [0:7] aen0, men0, cen0, ren0, den0;
  logic [0:7][1:0] ma0, mb0, mc0; logic [0:7][8:0] op0;
  fios_mm_sched #(.S(8), .FOLD(0), .PE_NB(8), .PE_DELAY(7), .M_LAT(3), .RES_LAT(4)) u0 (
    .clock_i(clk), .reset_n_i(rst_n), .start_i(start), .busy_o(busy0), .done_o(done0),
    .bp_rd_en_o(rd0), .bp_addr_o(addr0), .a_pass_o(apass0), .FIOS_input_sel_o(fsel0),
    .res_valid_o(resv0), .a_reg_en_o(aen0), .m_reg_en_o(men0), .CREG_en_o(cen0),
    .RES_delay_en_o(ren0), .C_input_delay_en_o(den0), .mux_A_sel_o(ma0),
    .mux_B_sel_o(mb0), .mux_C_sel_o(mc0), .OPMODE_o(op0));

  // FOLD instance
  logic busy1, done1, rd1, fsel1, resv1;
  logic [2:0] addr1; logic [1:0] apass1;
  logic [0:2] aen1, men1, cen1, ren1, den1;
  logic [0:2][1:0] ma1, mb1, mc1; logic [0:2][8:0] op1;
  fios_mm_sched #(.S(8), .FOLD(1), .PE_NB(3), .PE_DELAY(7), .M_LAT(3), .RES_LAT(4)) u1 (
    .clock_i(clk), .reset_n_i(rst_n), .start_i(start), .busy_o(busy1), .done_o(done1),
    .bp_rd_en_o(rd1), .bp_addr_o(addr1), .a_pass_o(apass1), .FIOS_input_sel_o(fsel1),
    .res_valid_o(resv1), .a_reg_en_o(aen1), .m_reg_en_o(men1), .CREG_en_o(cen1),
    .RES_delay_en_o(ren1), .C_input_delay_en_o(den1), .mux_A_sel_o(ma1),
    .mux_B_sel_o(mb1), .mux_C_sel_o(mc1), .OPMODE_o(op1));

  frame_t a0, a1;
  always_comb begin
    a0 = '0;
    a0.busy = busy0; a0.done = done0; a0.rd = rd0; a0.fsel = fsel0; a0.resv = resv0;
    a0.addr = 8'(addr0); a0.apass = 8'(apass0);
    for (int p = 0; p < 8; p++) begin
      a0.aen[p] = aen0[p]; a0.men[p] = men0[p]; a0.cen[p] = cen0[p];
      a0.ren[p] = ren0[p]; a0.den[p] = den0[p];
      a0.ma[2*p +: 2] = ma0[p]; a0.mb[2*p +: 2] = mb0[p]; a0.mc[2*p +: 2] = mc0[p];
      a0.op[9*p +: 9] = op0[p];
    end
  end
  always_comb begin
    a1 = '0;
    a1.busy = busy1; a1.done = done1; a1.rd = rd1; a1.fsel = fsel1; a1.resv = resv1;
    a1.addr = 8'(addr1); a1.apass = 8'(apass1);
    for (int p = 0; p < 3; p++) begin
      a1.aen[p] = aen1[p]; a1.men[p] = men1[p]; a1.cen[p] = cen1[p];
      a1.ren[p] = ren1[p]; a1.den[p] = den1[p];
      a1.ma[2*p +: 2] = ma1[p]; a1.mb[2*p +: 2] = mb1[p]; a1.mc[2*p +: 2] = mc1[p];
      a1.op[9*p +: 9] = op1[p];
    end
  end

  frame_t q0[$], q1[$];
  frame_t tl[0:127];
  int checks = 0, passes = 0, mcyc = 0;

  // Expected frames for one operation, cycle 0 = start acceptance cycle.
  task automatic build(input int S, input int NB, input int D, input int M,
                       input int R, input int FOLD, output int len);
    int t0l, tlast, c, p;
    for (int i = 0; i < 128; i++) tl[i] = '0;
    t0l   = 1 + (S-1)*D;
    tlast = t0l + 2*S + 1;
    len   = tlast + R + 2;
    for (int i = 1; i <= len-2; i++) tl[i].busy = 1'b1;
    tl[len-1].done = 1'b1;
    for (int k = 0; k <= 2*S-2; k += 2) begin
      tl[k].rd = 1'b1; tl[k].addr = 8'(k/2);
    end
    for (int j = 0; j < S; j++) begin
      p = j % NB;
      for (int k = 0; k <= 2*S+1; k++) begin
        c = 1 + j*D + k;
        tl[c].cen[p] = 1'b1;
        if (k == 1 + M) tl[c].men[p] = 1'b1;
        if (k == 0) begin
          tl[c].aen[p] = 1'b1; tl[c].op[9*p +: 9] = 9'h035;
        end else if (k == 1) begin
          tl[c].ma[2*p +: 2] = 2'd1; tl[c].mb[2*p +: 2] = 2'd2; tl[c].op[9*p +: 9] = 9'h005;
        end else if (k % 2 == 0) begin
          tl[c].mc[2*p +: 2] = 2'd1; tl[c].op[9*p +: 9] = 9'h035;
        end else begin
          tl[c].ma[2*p +: 2] = 2'd2; tl[c].mb[2*p +: 2] = 2'd1; tl[c].mc[2*p +: 2] = 2'd1;
          tl[c].op[9*p +: 9] = 9'h0B5; tl[c].den[p] = 1'b1; tl[c].ren[p] = 1'b1;
          if (j == S-1) tl[c+R].resv = 1'b1;
        end
      end
      if (FOLD != 0 && p == 0)
        for (int cc = 1 + j*D; cc <= tlast; cc++) tl[cc].apass = 8'(j/NB);
    end
    if (FOLD != 0 && NB < S)
      for (int cc = 1 + NB*D; cc <= tlast; cc++) tl[cc].fsel = 1'b1;
  endtask

  task automatic chk(input string nm, input logic [71:0] a, input logic [71:0] e);
    checks++;
    if (a === e) passes++;
    else $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, mcyc, a, e);
  endtask

  task automatic cmp(input string u, input frame_t a, input frame_t e);
    chk({u, ".busy_done_rd_fsel_resv"}, 72'({a.busy, a.done, a.rd, a.fsel, a.resv}),
        72'({e.busy, e.done, e.rd, e.fsel, e.resv}));
    chk({u, ".bp_addr"}, 72'(a.addr), 72'(e.addr));
    chk({u, ".a_pass"}, 72'(a.apass), 72'(e.apass));
    chk({u, ".a_reg_en"}, 72'(a.aen), 72'(e.aen));
    chk({u, ".m_reg_en"}, 72'(a.men), 72'(e.men));
    chk({u, ".creg_en"}, 72'(a.cen), 72'(e.cen));
    chk({u, ".res_delay_en"}, 72'(a.ren), 72'(e.ren));
    chk({u, ".c_delay_en"}, 72'(a.den), 72'(e.den));
    chk({u, ".mux_a"}, 72'(a.ma), 72'(e.ma));
    chk({u, ".mux_b"}, 72'(a.mb), 72'(e.mb));
    chk({u, ".mux_c"}, 72'(a.mc), 72'(e.mc));
    chk({u, ".opmode"}, a.op, e.op);
  endtask

  // Monitor: one expected frame per cycle while an operation is queued, else all-zero.
  frame_t e0, e1;
  always @(negedge clk) begin
    e0 = (q0.size() > 0) ? q0.pop_front() : '0;
    e1 = (q1.size() > 0) ? q1.pop_front() : '0;
    cmp("expand", a0, e0);
    cmp("fold", a1, e1);
    mcyc = mcyc + 1;
  end

  initial begin
    int len, nrst;
    nrst = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int cyc = 0; cyc < 1600; cyc++) begin
      @(posedge clk); #1;
      if (!rst_n) begin
        rst_n = 1'b1; start = 1'b0;
        continue;
      end
      if ((nrst == 0 && cyc >= 300 && q0.size() == 43) ||
          (nrst > 0 && nrst < 3 && q0.size() > 0 && $urandom_range(0, 199) == 0)) begin
        rst_n = 1'b0; start = 1'b0;
        q0.delete(); q1.delete();
        nrst++;
        continue;
      end
      if (cyc < 300) start = 1'b1;
      else if (q0.size() == 0) start = ($urandom_range(0, 5) == 0);
      else start = 1'($urandom_range(0, 1));
      if (start && q0.size() == 0 && q1.size() == 0) begin
        build(8, 8, 7, 3, 4, 0, len);
        for (int i = 0; i < len; i++) q0.push_back(tl[i]);
        build(8, 3, 7, 3, 4, 1, len);
        for (int i = 0; i < len; i++) q1.push_back(tl[i]);
      end
    end
    start = 1'b0;
    repeat (80) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
